// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - active-low 7-segment codes and BCD limits
package seg7_pkg;
  // Bit order gfedcba, segment on when bit is 0
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_MAX   = 4'd9;
endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD digit to active-low 7-segment decode
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/match_event_counter.sv
// rtl/match_event_counter.sv - BCD count of detector matches with HEX display and stretched LED
module match_event_counter
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int STRETCH  = 3,
  parameter int SATURATE = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  match,
  input  logic                  clr,
  input  logic                  hold,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  ovf,
  output logic                  match_led
);

  localparam int SW = $clog2(STRETCH + 1);

  logic [4*DIGITS-1:0] count_q, count_d, inc;
  logic                ovf_q, ovf_d;
  logic [SW-1:0]       stretch_q, stretch_d;
  logic                carry;

  // Ripple BCD increment; carry left set means every digit was 9
  always_comb begin
    inc   = count_q;
    carry = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (count_q[4*k +: 4] == BCD_MAX) begin
          inc[4*k +: 4] = 4'd0;
        end else begin
          inc[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (!hold && match) begin
      ovf_d   = ovf_q | carry;
      count_d = (carry && (SATURATE != 0)) ? count_q : inc;
    end
  end

  // LED stretch is independent of clr/hold so every sampled match is visible
  always_comb begin
    stretch_d = stretch_q;
    if (match) begin
      stretch_d = SW'(STRETCH);
    end else if (stretch_q != '0) begin
      stretch_d = stretch_q - SW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q   <= '0;
      ovf_q     <= 1'b0;
      stretch_q <= '0;
    end else begin
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      stretch_q <= stretch_d;
    end
  end

  assign count_bcd = count_q;
  assign ovf       = ovf_q;
  assign match_led = (stretch_q != '0);

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_to_seg7 u_seg (
      .bcd (count_q[4*k +: 4]),
      .seg (hex[7*k +: 7])
    );
  end

endmodule
